aes_encrypt_round_ctrl: RTL and testbench
=========================================

// Module: aes_encrypt_round_ctrl
// PURPOSE
//  Iterative AES-128 encrypt sequencer. Accepts one plaintext block over a valid/ready handshake.
//  Performs the initial AddRoundKey (whitening) itself. Then drives a shared external round datapath
//  NR times: rounds 1..NR-1 are full rounds, round NR is the final round (no MixColumns).
//  Returns the ciphertext over a valid/ready handshake.
//  Sits between the host interface, the round-key store (combinational lookup by index) and the
//  registered round datapath.
// PARAMETERS
//  DW         128  block / round-key width
//  NR         10   number of rounds (AES-128)
//  ROUND_LAT  1    datapath latency, in clocks, from stable dp_state_in/dp_round_key to valid dp_state_out; >=1
// PORTS
//  clk           in   1    system clock, rising edge
//  rst_n         in   1    asynchronous active-low reset
//  in_valid      in   1    plaintext offered
//  in_ready      out  1    controller can accept (IDLE only)
//  in_data       in   DW   plaintext block
//  out_valid     out  1    ciphertext available
//  out_ready     in   1    sink accepts ciphertext
//  out_data      out  DW   ciphertext block
//  key_idx       out  4    round-key index to key store (0..NR)
//  rk_in         in   DW   round key for key_idx, same-cycle (combinational store)
//  dp_state_in   out  DW   state presented to round datapath
//  dp_round_key  out  DW   round key forwarded to datapath (= rk_in)
//  dp_final      out  1    1 = datapath must use final-round path (skip MixColumns)
//  dp_state_out  in   DW   round datapath result
//  busy          out  1    high in any state other than IDLE
//  round_cnt     out  4    current round number (0 in IDLE/DONE)
// BEHAVIOUR
//  - FSM states: IDLE, RUN, DONE. Reset (rst_n=0, async) -> IDLE.
//    Reset values: in_ready=1, out_valid=0, busy=0, round_cnt=0, key_idx=0, dp_final=0;
//    state reg, dp_state_in and out_data = 0.
//  - IDLE: in_ready=1, key_idx=0.
//    On in_valid & in_ready edge: state <= in_data ^ rk_in, round_cnt <= 1, lat_cnt <= 0; go to RUN.
//  - RUN: in_ready=0; key_idx = round_cnt; dp_state_in = state reg; dp_round_key = rk_in;
//    dp_final = (round_cnt==NR). These outputs are held stable for the whole round.
//    lat_cnt increments each clock. On the edge where lat_cnt==ROUND_LAT:
//    state <= dp_state_out and lat_cnt <= 0.
//    If round_cnt<NR, round_cnt++; otherwise go to DONE.
//    Each round occupies ROUND_LAT+1 clocks.
//  - DONE: out_valid=1, out_data = state reg, stable until accepted; round_cnt=0.
//    On out_valid & out_ready edge: go to IDLE.
//    in_ready stays 0 in DONE, so there is no same-cycle accept; there is a mandatory 1-cycle
//    IDLE bubble between blocks.
//  - Latency: call the accept edge cycle 0. RUN spans cycles 1..NR*(ROUND_LAT+1).
//    out_valid rises in cycle NR*(ROUND_LAT+1)+1 (21 for the defaults).
//  - Backpressure: out_valid and out_data hold indefinitely while out_ready=0; no data loss.
//  - in_valid during RUN/DONE is ignored (in_ready=0); in_data is sampled only on the accept edge.
//  - Async reset mid-RUN or mid-DONE: the block is abandoned. Outputs return to reset values
//    immediately. No out_valid pulse follows reset release.
//  - round_cnt and lat_cnt are sized so that no wrap occurs; illegal FSM encodings go to IDLE.
// TESTING
//  1 FIPS-197 C.1 with real key store and datapath:
//    key 000102..0f, pt 00112233445566778899aabbccddeeff ->
//    out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid in cycle 21.
//  2 Sequence check: key_idx reads 0 in IDLE, then 1..10 with each value held 2 clocks;
//    dp_final=1 only while key_idx=10.
//  3 Backpressure: hold out_ready=0 for 50 cycles after out_valid ->
//    out_data stable, in_ready=0; release -> IDLE next cycle.
//  4 Back-to-back: in_valid held high with two blocks, out_ready=1 ->
//    second accept exactly 1 IDLE cycle after the first out handshake; both ciphertexts correct.
//  5 Reset: assert rst_n=0 at round 5 -> busy=0 and in_ready=1 asynchronously;
//    a fresh block after release gives the correct ciphertext.
//  6 ROUND_LAT=3 build with a 3-stage model datapath -> vector 1 result, out_valid in cycle 41.

Source files
------------

// File: rtl/aes_encrypt_round_ctrl.sv
// ----------------------------------------------------------------------------
// aes_encrypt_round_ctrl
//
// Iterative AES-128 encrypt sequencer. A plaintext block is accepted over a
// valid/ready handshake and whitened with round key 0. An external registered
// round datapath is then driven NR times. Rounds 1..NR-1 are full rounds, and
// round NR is the final round without MixColumns. The ciphertext is returned
// over a valid/ready handshake.
//
// Parameters
//   DW         block / round-key width
//   NR         number of rounds (at most 15)
//   ROUND_LAT  datapath latency in clocks (>= 1); each round lasts ROUND_LAT+1
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     plaintext handshake (ready only in IDLE)
//   in_data               plaintext block
//   out_valid/out_ready   ciphertext handshake (valid only in DONE)
//   out_data              ciphertext block (the state register)
//   key_idx, rk_in        round-key store lookup (combinational store)
//   dp_state_in           state presented to the round datapath
//   dp_round_key          round key forwarded to the datapath (= rk_in)
//   dp_final              selects the final-round path of the datapath
//   dp_state_out          round datapath result
//   busy                  high in every state except IDLE
//   round_cnt             current round number (0 outside RUN)
// ----------------------------------------------------------------------------
module aes_encrypt_round_ctrl #(
   parameter int DW        = 128,
   parameter int NR        = 10,
   parameter int ROUND_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [3:0]    key_idx,
   input  logic [DW-1:0] rk_in,
   output logic [DW-1:0] dp_state_in,
   output logic [DW-1:0] dp_round_key,
   output logic          dp_final,
   input  logic [DW-1:0] dp_state_out,
   output logic          busy,
   output logic [3:0]    round_cnt
);

   // lat_q only has to count 0..ROUND_LAT, so it can never wrap.
   localparam int            LW      = $clog2(ROUND_LAT + 1);
   localparam logic [LW-1:0] LAT_MAX = LW'(ROUND_LAT);
   localparam logic [3:0]    NR_LAST = 4'(NR);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] data_q, data_d;
   logic [3:0]    round_q, round_d;
   logic [LW-1:0] lat_q, lat_d;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         round_q <= '0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         round_q <= round_d;
         lat_q   <= lat_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      round_d = round_q;
      lat_d   = lat_q;
      case (state_q)
         S_IDLE: begin
            // key_idx is 0 in IDLE, so rk_in is the whitening key here.
            if (in_valid) begin
               state_d = S_RUN;
               data_d  = in_data ^ rk_in;
               round_d = 4'd1;
               lat_d   = '0;
            end
         end
         S_RUN: begin
            if (lat_q == LAT_MAX) begin
               // The datapath inputs have been stable for ROUND_LAT clocks.
               data_d = dp_state_out;
               lat_d  = '0;
               if (round_q < NR_LAST) begin
                  round_d = round_q + 4'd1;
               end else begin
                  round_d = '0;
                  state_d = S_DONE;
               end
            end else begin
               lat_d = lat_q + LW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            round_d = '0;
            lat_d   = '0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      key_idx   = 4'd0;
      round_cnt = 4'd0;
      dp_final  = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         S_RUN: begin
            key_idx   = round_q;
            round_cnt = round_q;
            dp_final  = (round_q == NR_LAST);
         end
         S_DONE: begin
            out_valid = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   // The state register feeds both the datapath and the output port. It only
   // changes on round boundaries, so both stay stable for a whole round and
   // for the entire DONE phase.
   assign out_data     = data_q;
   assign dp_state_in  = data_q;
   assign dp_round_key = rk_in;

endmodule

// File: tb/tb_aes_encrypt_round_ctrl.sv
// ----------------------------------------------------------------------------
// tb_aes_encrypt_round_ctrl
//
// Drives two controller instances. The first uses ROUND_LAT=1 and the second
// uses ROUND_LAT=3. Each instance is attached to a behavioural round-key store
// and to an AES round datapath of matching latency. Ciphertexts are compared
// with a software AES-128 model and with the FIPS-197 C.1 vector. Timing is
// compared with cycle counts derived from NR and ROUND_LAT.
// ----------------------------------------------------------------------------
module tb_aes_encrypt_round_ctrl;

   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   // ROUND_LAT = 1 instance
   logic         in_valid, in_ready, out_valid, out_ready, dp_final, busy;
   logic [127:0] in_data, out_data, rk_in, dp_state_in, dp_round_key, dp_state_out;
   logic [3:0]   key_idx, round_cnt;
   // ROUND_LAT = 3 instance
   logic         in_valid3, in_ready3, out_valid3, out_ready3, dp_final3, busy3;
   logic [127:0] in_data3, out_data3, rk_in3, dp_state_in3, dp_round_key3, dp_state_out3;
   logic [3:0]   key_idx3, round_cnt3;

   int errors = 0;
   int checks = 0;

   logic [127:0] rkeys [0:10];

   aes_encrypt_round_ctrl #(.DW(128), .NR(10), .ROUND_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .key_idx(key_idx), .rk_in(rk_in),
      .dp_state_in(dp_state_in), .dp_round_key(dp_round_key), .dp_final(dp_final),
      .dp_state_out(dp_state_out), .busy(busy), .round_cnt(round_cnt)
   );

   aes_encrypt_round_ctrl #(.DW(128), .NR(10), .ROUND_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
      .key_idx(key_idx3), .rk_in(rk_in3),
      .dp_state_in(dp_state_in3), .dp_round_key(dp_round_key3), .dp_final(dp_final3),
      .dp_state_out(dp_state_out3), .busy(busy3), .round_cnt(round_cnt3)
   );

   // ---------------- AES-128 arithmetic ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // The S-box is computed as the GF(2^8) inverse (x^254) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq = x;
      logic [7:0] inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] next_rk(input logic [127:0] rk, input int rnd);
      logic [7:0]  rcon = 8'h01;
      logic [31:0] w3, rot, t, n0, n1, n2, n3;
      for (int j = 1; j < rnd; j++) rcon = xt(rcon);
      w3  = rk[31:0];
      rot = {w3[23:0], w3[31:24]};
      t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon, 24'h0};
      n0  = rk[127:96] ^ t;
      n1  = rk[95:64] ^ n0;
      n2  = rk[63:32] ^ n1;
      n3  = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic fin);
      logic [7:0]   a [16];
      logic [7:0]   t [16];
      logic [7:0]   b0, b1, b2, b3;
      logic [127:0] r;
      for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++)
            t[rr+4*c] = a[rr+4*((c+rr)%4)];
      if (!fin) begin
         for (int c = 0; c < 4; c++) begin
            b0 = t[4*c]; b1 = t[4*c+1]; b2 = t[4*c+2]; b3 = t[4*c+3];
            t[4*c]   = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
            t[4*c+1] = b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3;
            t[4*c+2] = b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3;
            t[4*c+3] = xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3);
         end
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
      return r ^ rk;
   endfunction

   // Reference model: a complete AES-128 encryption.
   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [127:0] rk = key;
      logic [127:0] s  = pt ^ key;
      for (int r = 1; r <= 10; r++) begin
         rk = next_rk(rk, r);
         s  = aes_round(s, rk, r == 10);
      end
      return s;
   endfunction

   task automatic load_key(input logic [127:0] k);
      rkeys[0] = k;
      for (int r = 1; r <= 10; r++) rkeys[r] = next_rk(rkeys[r-1], r);
   endtask

   // ---------------- Key stores and datapaths ----------------
   assign rk_in  = (key_idx  <= 4'd10) ? rkeys[key_idx]  : 128'h0;
   assign rk_in3 = (key_idx3 <= 4'd10) ? rkeys[key_idx3] : 128'h0;

   logic [127:0] dp_q;
   logic [127:0] pipe3 [0:2];
   always @(posedge clk) begin
      dp_q     <= aes_round(dp_state_in, dp_round_key, dp_final);
      pipe3[0] <= aes_round(dp_state_in3, dp_round_key3, dp_final3);
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign dp_state_out  = dp_q;
   assign dp_state_out3 = pipe3[2];

   // Sends one block to the ROUND_LAT=1 instance (which must be IDLE, with
   // out_ready=1). lat is the cycle in which out_valid was first seen (accept
   // edge = cycle 0), or -1 if it never rose.
   task automatic send_block(input logic [127:0] pt, output logic [127:0] ct, output int lat);
      in_data  = pt;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) lat = -1;
      ct = out_data;
      @(negedge clk);
   endtask

   // ---------------- Tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;  in_data = '0;  out_ready = 1'b0;
      in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0;
      load_key(128'h0);
      #12;
      checks++;
      if ({in_ready, out_valid, busy, round_cnt, key_idx, dp_final} !== {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=%b", {in_ready, out_valid, busy, round_cnt, key_idx, dp_final},
                  {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0});
      end
      checks++;
      if ({out_data, dp_state_in} !== 256'h0) begin
         errors++;
         $display("FAIL reset_data got=%h/%h exp=0", out_data, dp_state_in);
      end
      checks++;
      if ({in_ready3, out_valid3, busy3, round_cnt3} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL reset_lat3 got=%b exp=1000000", {in_ready3, out_valid3, busy3, round_cnt3});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, busy, out_valid} !== 3'b100) begin
         errors++;
         $display("FAIL reset_release got=%b exp=100", {in_ready, busy, out_valid});
      end
   endtask

   task automatic test_fips();
      logic [127:0] ct;
      int lat;
      load_key(FIPS_KEY);
      out_ready = 1'b1;
      send_block(FIPS_PT, ct, lat);
      checks++;
      if (ct !== FIPS_CT) begin
         errors++;
         $display("FAIL fips_ct got=%h exp=%h", ct, FIPS_CT);
      end
      checks++;
      if (lat !== 21) begin
         errors++;
         $display("FAIL fips_latency got=%0d exp=21", lat);
      end
      $display("fips: ct=%h latency=%0d", ct, lat);
   endtask

   task automatic test_sequence();
      logic [127:0] key, pt;
      int exp_idx;
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      out_ready = 1'b1;
      in_data   = pt;
      in_valid  = 1'b1;
      checks++;
      if ({key_idx, in_ready} !== {4'd0, 1'b1}) begin
         errors++;
         $display("FAIL seq_idle got idx=%0d rdy=%b exp idx=0 rdy=1", key_idx, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (dp_state_in !== (pt ^ key)) begin
         errors++;
         $display("FAIL seq_whiten got=%h exp=%h", dp_state_in, pt ^ key);
      end
      for (int c = 1; c <= 20; c++) begin
         exp_idx = (c + 1) / 2;
         checks++;
         if ({key_idx, round_cnt, dp_final, busy, in_ready} !==
             {4'(exp_idx), 4'(exp_idx), exp_idx == 10, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL seq_cycle%0d got idx=%0d rnd=%0d fin=%b busy=%b rdy=%b exp idx=rnd=%0d fin=%b",
                     c, key_idx, round_cnt, dp_final, busy, in_ready, exp_idx, exp_idx == 10);
         end
         @(negedge clk);
      end
      checks++;
      if ({out_valid, round_cnt, out_data} !== {1'b1, 4'd0, aes_enc(key, pt)}) begin
         errors++;
         $display("FAIL seq_done got v=%b rnd=%0d ct=%h exp v=1 rnd=0 ct=%h",
                  out_valid, round_cnt, out_data, aes_enc(key, pt));
      end
      @(negedge clk);
      checks++;
      if ({in_ready, busy} !== 2'b10) begin
         errors++;
         $display("FAIL seq_back_idle got=%b exp=10", {in_ready, busy});
      end
      $display("sequence: key_idx/dp_final trace over 20 run cycles");
   endtask

   task automatic test_random();
      logic [127:0] key, pt, ct, exp;
      int lat;
      out_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         load_key(key);
         exp = aes_enc(key, pt);
         send_block(pt, ct, lat);
         checks++;
         if (ct !== exp || lat !== 21) begin
            errors++;
            $display("FAIL random%0d got ct=%h lat=%0d exp ct=%h lat=21", n, ct, lat, exp);
         end
         $display("random%0d: pt=%h ct=%h lat=%0d", n, pt, ct, lat);
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] key, pt, exp;
      int lat;
      int bad;
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      exp = aes_enc(key, pt);
      out_ready = 1'b0;
      in_data   = pt;
      in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      // Keep offering a different block while busy; it must be ignored.
      in_data = ~pt;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== 21) begin
         errors++;
         $display("FAIL bp_latency got=%0d exp=21", lat);
      end
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, exp}) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_hold got %0d unstable cycles exp 0 (ct=%h exp=%h)", bad, out_data, exp);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL bp_release got=%b exp=100", {in_ready, out_valid, busy});
      end
      $display("backpressure: held 50 cycles, ct=%h", exp);
   endtask

   task automatic test_back_to_back();
      logic [127:0] key, pa, pb;
      int acc[$];
      int hs[$];
      logic [127:0] cts[$];
      key = {$urandom, $urandom, $urandom, $urandom};
      pa  = {$urandom, $urandom, $urandom, $urandom};
      pb  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      out_ready = 1'b1;
      for (int cyc = 0; cyc <= 60; cyc++) begin
         in_data  = (acc.size() == 0) ? pa : pb;
         in_valid = (acc.size() < 2);
         if (in_valid && in_ready) acc.push_back(cyc);
         if (out_valid && out_ready) begin
            hs.push_back(cyc);
            cts.push_back(out_data);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      while (acc.size() < 2) acc.push_back(-1);
      while (hs.size() < 2) hs.push_back(-1);
      while (cts.size() < 2) cts.push_back('x);
      checks++;
      if (acc[1] - hs[0] !== 1 || hs[0] !== 21 || hs[1] !== 43) begin
         errors++;
         $display("FAIL b2b_timing got acc=%0d,%0d hs=%0d,%0d exp acc=0,22 hs=21,43",
                  acc[0], acc[1], hs[0], hs[1]);
      end
      checks++;
      if (cts[0] !== aes_enc(key, pa)) begin
         errors++;
         $display("FAIL b2b_ct0 got=%h exp=%h", cts[0], aes_enc(key, pa));
      end
      checks++;
      if (cts[1] !== aes_enc(key, pb)) begin
         errors++;
         $display("FAIL b2b_ct1 got=%h exp=%h", cts[1], aes_enc(key, pb));
      end
      $display("back_to_back: accepts %0d,%0d handshakes %0d,%0d", acc[0], acc[1], hs[0], hs[1]);
   endtask

   task automatic test_reset_mid();
      logic [127:0] key, pt, ct;
      int lat;
      int n;
      int seen;
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      out_ready = 1'b1;
      in_data   = pt;
      in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (round_cnt != 4'd5 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (round_cnt !== 4'd5) begin
         errors++;
         $display("FAIL rst_reach_round5 got=%0d exp=5", round_cnt);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, in_ready, out_valid, round_cnt, key_idx, dp_final, out_data} !==
          {1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 128'h0}) begin
         errors++;
         $display("FAIL rst_async got busy=%b rdy=%b v=%b rnd=%0d idx=%0d out=%h exp 0,1,0,0,0,0",
                  busy, in_ready, out_valid, round_cnt, key_idx, out_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         if (out_valid || busy) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL rst_no_output got %0d active cycles exp 0", seen);
      end
      pt = {$urandom, $urandom, $urandom, $urandom};
      send_block(pt, ct, lat);
      checks++;
      if (ct !== aes_enc(key, pt) || lat !== 21) begin
         errors++;
         $display("FAIL rst_fresh got ct=%h lat=%0d exp ct=%h lat=21", ct, lat, aes_enc(key, pt));
      end
      $display("reset_mid: abandoned at round 5, fresh ct=%h", ct);
   endtask

   task automatic test_lat3();
      logic [127:0] key, pt, exp;
      int lat;
      out_ready3 = 1'b1;
      for (int v = 0; v < 2; v++) begin
         key = (v == 0) ? FIPS_KEY : {$urandom, $urandom, $urandom, $urandom};
         pt  = (v == 0) ? FIPS_PT  : {$urandom, $urandom, $urandom, $urandom};
         load_key(key);
         exp = aes_enc(key, pt);
         in_data3  = pt;
         in_valid3 = 1'b1;
         @(posedge clk);
         @(negedge clk);
         in_valid3 = 1'b0;
         lat = 1;
         while (!out_valid3 && lat < 300) begin
            @(negedge clk);
            lat++;
         end
         checks++;
         if (out_data3 !== exp || lat !== 41) begin
            errors++;
            $display("FAIL lat3_vec%0d got ct=%h lat=%0d exp ct=%h lat=41", v, out_data3, lat, exp);
         end
         if (v == 0) begin
            checks++;
            if (out_data3 !== FIPS_CT) begin
               errors++;
               $display("FAIL lat3_fips got=%h exp=%h", out_data3, FIPS_CT);
            end
         end
         $display("lat3_vec%0d: ct=%h latency=%0d", v, out_data3, lat);
         @(negedge clk);
      end
      out_ready3 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fips();
      test_sequence();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_lat3();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
